// File: rtl/cu_pkg.sv
// Shared opcode constants, class/state enums and datapath mux encodings
// for the multi-cycle control unit.
package cu_pkg;

   localparam logic [4:0] OPC_J    = 5'd11;
   localparam logic [4:0] OPC_BEZ  = 5'd12;
   localparam logic [4:0] OPC_MFHI = 5'd13;
   localparam logic [4:0] OPC_MFLO = 5'd14;
   localparam logic [4:0] OPC_MUL  = 5'd15;
   localparam logic [4:0] OPC_LW   = 5'd16;
   localparam logic [4:0] OPC_SW   = 5'd17;
   localparam int unsigned OPC_NUM = 18;

   localparam logic [3:0] ULA_OP_ADD = 4'd0;
   localparam logic [3:0] ULA_OP_BEZ = 4'd12;

   localparam logic       UA_PC  = 1'b0;
   localparam logic       UA_REG = 1'b1;

   localparam logic [1:0] UB_REG = 2'd0;
   localparam logic [1:0] UB_ONE = 2'd1;
   localparam logic [1:0] UB_IMM = 2'd2;

   localparam logic [1:0] CP_ALU  = 2'd0;
   localparam logic [1:0] CP_ALUS = 2'd1;
   localparam logic [1:0] CP_IMM  = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_HI  = 2'd1;
   localparam logic [1:0] WB_LO  = 2'd2;
   localparam logic [1:0] WB_MEM = 2'd3;

   typedef enum logic [3:0] {
      CL_R, CL_I, CL_J, CL_BEZ, CL_MFHI, CL_MFLO, CL_MUL, CL_LW, CL_SW, CL_ILL
   } cls_t;

   typedef enum logic [2:0] {
      S_EXE, S_MUL, S_MEM, S_WB, S_HALT
   } state_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control unit <-> datapath/memory/multiplier signal bundle.
// master drives the instruction and status inputs; slave is the control unit.
interface mc_control_unit_if #(
   parameter int unsigned OP_W = 5
);
   logic [OP_W-1:0] op_code;
   logic            zero;
   logic            mul_done;
   logic            mem_ready;
   logic            exe;
   logic            wb;
   logic [3:0]      ula_op;
   logic            ula_a;
   logic [1:0]      ula_b;
   logic [1:0]      fonte_cp;
   logic [1:0]      fonte_wb;
   logic            r_w;
   logic            mul_start;
   logic            mem_req;
   logic            mem_we;
   logic            retire;
   logic            illegal;
   logic            mul_timeout;

   modport master (
      output op_code, zero, mul_done, mem_ready,
      input  exe, wb, ula_op, ula_a, ula_b, fonte_cp, fonte_wb, r_w,
             mul_start, mem_req, mem_we, retire, illegal, mul_timeout
   );

   modport slave (
      input  op_code, zero, mul_done, mem_ready,
      output exe, wb, ula_op, ula_a, ula_b, fonte_cp, fonte_wb, r_w,
             mul_start, mem_req, mem_we, retire, illegal, mul_timeout
   );
endinterface

// File: rtl/cu_decode.sv
// Opcode classifier: maps op_code to an instruction class; anything outside
// the defined opcode map is flagged illegal.
module cu_decode
   import cu_pkg::*;
#(
   parameter int unsigned OP_W = 5
) (
   input  logic [OP_W-1:0] op_code,
   output cls_t            cls,
   output logic            illegal
);

   always_comb begin
      cls = CL_ILL;
      case (op_code[4:0])
         5'd0, 5'd1, 5'd3, 5'd4, 5'd5:         cls = CL_R;
         5'd2, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10:  cls = CL_I;
         OPC_J:                                cls = CL_J;
         OPC_BEZ:                              cls = CL_BEZ;
         OPC_MFHI:                             cls = CL_MFHI;
         OPC_MFLO:                             cls = CL_MFLO;
         OPC_MUL:                              cls = CL_MUL;
         OPC_LW:                               cls = CL_LW;
         OPC_SW:                               cls = CL_SW;
         default:                              cls = CL_ILL;
      endcase
      // Upper opcode bits of wider builds must be zero
      if (op_code >= OP_W'(OPC_NUM)) cls = CL_ILL;
   end

   assign illegal = (cls == CL_ILL);

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: EXE -> [MUL | MEM] -> WB sequencing with multiplier
// timeout and illegal-opcode trap into a halt state left only by reset.
module mc_control_unit
   import cu_pkg::*;
#(
   parameter int unsigned OP_W    = 5,
   parameter int unsigned MUL_MAX = 32
) (
   input logic            clk,
   input logic            rst,
   mc_control_unit_if.slave bus
);

   localparam int unsigned MCNT_W = (MUL_MAX > 1) ? $clog2(MUL_MAX) : 1;

   state_t              state, state_nxt;
   cls_t                cls;
   logic                dec_illegal;
   logic [MCNT_W-1:0]   mcnt;
   logic                zero_q;
   logic                illegal_q, mul_timeout_q;
   logic                set_illegal_c, set_timeout_c;
   logic                mul_limit_c;
   logic                src_a_c;
   logic [1:0]          src_b_c;

   logic                exe_c, wb_c, ula_a_c, r_w_c, mul_start_c;
   logic                mem_req_c, mem_we_c, retire_c;
   logic [3:0]          ula_op_c;
   logic [1:0]          ula_b_c, fonte_cp_c, fonte_wb_c;

   cu_decode #(.OP_W(OP_W)) u_decode (
      .op_code (bus.op_code),
      .cls     (cls),
      .illegal (dec_illegal)
   );

   // ALU source selection used in EXE and held through MEM
   always_comb begin
      src_a_c = UA_PC;
      src_b_c = UB_REG;
      case (cls)
         CL_R, CL_BEZ, CL_MUL: begin
            src_a_c = UA_REG;
            src_b_c = UB_REG;
         end
         CL_I, CL_LW, CL_SW: begin
            src_a_c = UA_REG;
            src_b_c = UB_IMM;
         end
         default: ;
      endcase
   end

   assign mul_limit_c = (mcnt == MCNT_W'(MUL_MAX - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_EXE;
      else     state <= state_nxt;
   end

   // Next state and combinational control outputs
   always_comb begin
      state_nxt     = state;
      exe_c         = 1'b0;
      wb_c          = 1'b0;
      ula_op_c      = ULA_OP_ADD;
      ula_a_c       = UA_PC;
      ula_b_c       = UB_REG;
      fonte_cp_c    = CP_ALU;
      fonte_wb_c    = WB_ALU;
      r_w_c         = 1'b0;
      mul_start_c   = 1'b0;
      mem_req_c     = 1'b0;
      mem_we_c      = 1'b0;
      retire_c      = 1'b0;
      set_illegal_c = 1'b0;
      set_timeout_c = 1'b0;

      case (state)
         S_EXE: begin
            exe_c    = 1'b1;
            ula_op_c = bus.op_code[3:0];
            ula_a_c  = src_a_c;
            ula_b_c  = src_b_c;
            if (dec_illegal) begin
               set_illegal_c = 1'b1;
               state_nxt     = S_HALT;
            end else if (cls == CL_MUL) begin
               mul_start_c = 1'b1;
               state_nxt   = S_MUL;
            end else if (cls == CL_LW || cls == CL_SW) begin
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_WB;
            end
         end

         S_MUL: begin
            // A done on the limit cycle still completes normally
            if (bus.mul_done) begin
               state_nxt = S_WB;
            end else if (mul_limit_c) begin
               set_timeout_c = 1'b1;
               state_nxt     = S_HALT;
            end
         end

         S_MEM: begin
            mem_req_c = 1'b1;
            mem_we_c  = (cls == CL_SW);
            ula_op_c  = bus.op_code[3:0];
            ula_a_c   = src_a_c;
            ula_b_c   = src_b_c;
            if (bus.mem_ready) state_nxt = S_WB;
         end

         S_WB: begin
            wb_c      = 1'b1;
            retire_c  = 1'b1;
            state_nxt = S_EXE;
            if (cls == CL_BEZ && zero_q) begin
               fonte_cp_c = CP_ALUS;
               ula_op_c   = ULA_OP_BEZ;
               ula_a_c    = UA_REG;
               ula_b_c    = UB_REG;
            end else begin
               ula_op_c = ULA_OP_ADD;
               ula_a_c  = UA_PC;
               ula_b_c  = UB_ONE;
               case (cls)
                  CL_J:    fonte_cp_c = CP_IMM;
                  CL_BEZ:  fonte_cp_c = CP_ALUS;
                  default: fonte_cp_c = CP_ALU;
               endcase
            end
            r_w_c = !(cls inside {CL_J, CL_BEZ, CL_MUL, CL_SW});
            case (cls)
               CL_MFHI: fonte_wb_c = WB_HI;
               CL_MFLO: fonte_wb_c = WB_LO;
               CL_LW:   fonte_wb_c = WB_MEM;
               default: fonte_wb_c = WB_ALU;
            endcase
         end

         S_HALT: state_nxt = S_HALT;

         default: state_nxt = S_EXE;
      endcase
   end

   // Branch condition captured in EXE, multiplier cycle counter, sticky errors
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q        <= 1'b0;
         mcnt          <= '0;
         illegal_q     <= 1'b0;
         mul_timeout_q <= 1'b0;
      end else begin
         if (state == S_EXE) zero_q <= bus.zero;
         if (state == S_MUL) mcnt <= (state_nxt == S_MUL) ? mcnt + MCNT_W'(1) : '0;
         if (set_illegal_c) illegal_q <= 1'b1;
         if (set_timeout_c) mul_timeout_q <= 1'b1;
      end
   end

   assign bus.exe         = exe_c;
   assign bus.wb          = wb_c;
   assign bus.ula_op      = ula_op_c;
   assign bus.ula_a       = ula_a_c;
   assign bus.ula_b       = ula_b_c;
   assign bus.fonte_cp    = fonte_cp_c;
   assign bus.fonte_wb    = fonte_wb_c;
   assign bus.r_w         = r_w_c;
   assign bus.mul_start   = mul_start_c;
   assign bus.mem_req     = mem_req_c;
   assign bus.mem_we      = mem_we_c;
   assign bus.retire      = retire_c;
   assign bus.illegal     = illegal_q;
   assign bus.mul_timeout = mul_timeout_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed cases plus a random
// instruction stream compared against a per-phase behavioural model.
module tb_mc_control_unit;

   localparam int unsigned OP_W    = 5;
   localparam int unsigned MUL_MAX = 32;

   localparam int K_R = 0, K_I = 1, K_J = 2, K_BEZ = 3, K_HI = 4, K_LO = 5,
                  K_MUL = 6, K_LW = 7, K_SW = 8, K_ILL = 9;

   typedef struct packed {
      logic       exe;
      logic       wb;
      logic [3:0] ula_op;
      logic       ula_a;
      logic [1:0] ula_b;
      logic [1:0] fonte_cp;
      logic [1:0] fonte_wb;
      logic       r_w;
      logic       mul_start;
      logic       mem_req;
      logic       mem_we;
      logic       retire;
      logic       illegal;
      logic       mul_timeout;
   } ov_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   retire_cnt = 0;
   int   exp_retire = 0;
   bit   exp_ill = 1'b0;
   bit   exp_to  = 1'b0;

   mc_control_unit_if #(.OP_W(OP_W)) bus();

   mc_control_unit #(.OP_W(OP_W), .MUL_MAX(MUL_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.retire === 1'b1) retire_cnt++;

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int cls_of(input int op);
      case (op)
         0, 1, 3, 4, 5:        return K_R;
         2, 6, 7, 8, 9, 10:    return K_I;
         11:                   return K_J;
         12:                   return K_BEZ;
         13:                   return K_HI;
         14:                   return K_LO;
         15:                   return K_MUL;
         16:                   return K_LW;
         17:                   return K_SW;
         default:              return K_ILL;
      endcase
   endfunction

   function automatic logic [2:0] src_of(input int c);
      if (c == K_R || c == K_BEZ || c == K_MUL) return 3'b100;
      if (c == K_I || c == K_LW || c == K_SW)   return 3'b110;
      return 3'b000;
   endfunction

   function automatic ov_t base();
      ov_t o;
      o = '0;
      o.illegal     = exp_ill;
      o.mul_timeout = exp_to;
      return o;
   endfunction

   function automatic ov_t exp_exe(input int op);
      ov_t o;
      o = base();
      o.exe       = 1'b1;
      o.ula_op    = 4'(op);
      {o.ula_a, o.ula_b} = src_of(cls_of(op));
      o.mul_start = (cls_of(op) == K_MUL);
      return o;
   endfunction

   function automatic ov_t exp_mem(input int op);
      ov_t o;
      o = base();
      o.mem_req = 1'b1;
      o.mem_we  = (cls_of(op) == K_SW);
      o.ula_op  = 4'(op);
      {o.ula_a, o.ula_b} = src_of(cls_of(op));
      return o;
   endfunction

   function automatic ov_t exp_wb(input int op, input bit zq);
      ov_t o;
      int  c;
      c = cls_of(op);
      o = base();
      o.wb     = 1'b1;
      o.retire = 1'b1;
      if (c == K_BEZ && zq) begin
         o.fonte_cp = 2'd1;
         o.ula_op   = 4'd12;
         o.ula_a    = 1'b1;
         o.ula_b    = 2'd0;
      end else begin
         o.ula_op   = 4'd0;
         o.ula_a    = 1'b0;
         o.ula_b    = 2'd1;
         o.fonte_cp = (c == K_J) ? 2'd2 : (c == K_BEZ) ? 2'd1 : 2'd0;
      end
      o.r_w      = (c == K_R || c == K_I || c == K_HI || c == K_LO || c == K_LW);
      o.fonte_wb = (c == K_HI) ? 2'd1 : (c == K_LO) ? 2'd2 : (c == K_LW) ? 2'd3 : 2'd0;
      return o;
   endfunction

   function automatic ov_t outs();
      ov_t o;
      o.exe = bus.exe;           o.wb = bus.wb;
      o.ula_op = bus.ula_op;     o.ula_a = bus.ula_a;
      o.ula_b = bus.ula_b;       o.fonte_cp = bus.fonte_cp;
      o.fonte_wb = bus.fonte_wb; o.r_w = bus.r_w;
      o.mul_start = bus.mul_start;
      o.mem_req = bus.mem_req;   o.mem_we = bus.mem_we;
      o.retire = bus.retire;     o.illegal = bus.illegal;
      o.mul_timeout = bus.mul_timeout;
      return o;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic halt_and_reset();
      int hop;
      hop = 0;
      for (int i = 0; i < 3; i++) begin
         hop            = int'($urandom_range(0, 31));
         bus.op_code    = OP_W'(hop);
         bus.zero       = 1'($urandom_range(0, 1));
         bus.mul_done   = 1'($urandom_range(0, 1));
         bus.mem_ready  = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("halt", 32'(outs()), 32'(base()));
         step();
      end
      rst = 1'b1;
      #1;
      exp_ill = 1'b0;
      exp_to  = 1'b0;
      chk("halt_rst", 32'(outs()), 32'(exp_exe(hop)));
      step();
      rst = 1'b0;
      bus.mul_done  = 1'b0;
      bus.mem_ready = 1'b0;
   endtask

   // One instruction; dly = handshake cycle index of done/ready (> MUL_MAX: none)
   task automatic run_instr(input int op, input bit z_exe, input int dly);
      int c;
      c = cls_of(op);
      bus.op_code   = OP_W'(op);
      bus.zero      = z_exe;
      bus.mul_done  = 1'($urandom_range(0, 1));
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("exe", 32'(outs()), 32'(exp_exe(op)));
      step();
      if (c == K_ILL) begin
         exp_ill = 1'b1;
         halt_and_reset();
         return;
      end
      if (c == K_MUL) begin
         for (int i = 1; i <= int'(MUL_MAX); i++) begin
            bus.mul_done  = (i == dly);
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.zero      = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("mul", 32'(outs()), 32'(base()));
            step();
            if (i == dly) break;
         end
         if (dly > int'(MUL_MAX)) begin
            exp_to = 1'b1;
            halt_and_reset();
            return;
         end
      end else if (c == K_LW || c == K_SW) begin
         for (int i = 1; i <= dly; i++) begin
            bus.mem_ready = (i == dly);
            bus.mul_done  = 1'($urandom_range(0, 1));
            bus.zero      = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("mem", 32'(outs()), 32'(exp_mem(op)));
            step();
         end
      end
      bus.zero      = !z_exe;
      bus.mul_done  = 1'($urandom_range(0, 1));
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("wb", 32'(outs()), 32'(exp_wb(op, z_exe)));
      exp_retire++;
      step();
      bus.mul_done  = 1'b0;
      bus.mem_ready = 1'b0;
   endtask

   initial begin
      int r, op, dly;
      rst           = 1'b1;
      bus.op_code   = '0;
      bus.zero      = 1'b0;
      bus.mul_done  = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("reset", 32'(outs()), 32'(exp_exe(0)));
      step();
      rst = 1'b0;

      // Directed cases
      run_instr(0, 1'b0, 0);
      run_instr(11, 1'b1, 0);
      run_instr(12, 1'b1, 0);
      run_instr(12, 1'b0, 0);
      run_instr(16, 1'b0, 3);
      run_instr(17, 1'b0, 3);
      run_instr(16, 1'b1, 1);
      run_instr(15, 1'b0, 5);
      run_instr(15, 1'b0, int'(MUL_MAX));
      run_instr(13, 1'b0, 0);
      run_instr(14, 1'b1, 0);
      run_instr(15, 1'b0, int'(MUL_MAX) + 1);
      run_instr(20, 1'b0, 0);
      run_instr(2, 1'b0, 0);

      // Reset in the middle of a memory wait
      bus.op_code   = OP_W'(16);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("abort_exe", 32'(outs()), 32'(exp_exe(16)));
      step();
      @(negedge clk);
      chk("abort_mem", 32'(outs()), 32'(exp_mem(16)));
      #2 rst = 1'b1;
      #1 chk("abort_rst", 32'(outs()), 32'(exp_exe(16)));
      step();
      rst = 1'b0;

      // Random instruction stream
      for (int n = 0; n < 200; n++) begin
         r  = int'($urandom_range(0, 99));
         op = (r < 8) ? int'($urandom_range(18, 31)) : int'($urandom_range(0, 17));
         if (cls_of(op) == K_MUL)
            dly = (int'($urandom_range(0, 99)) < 6) ? int'(MUL_MAX) + 1 : int'($urandom_range(1, 8));
         else
            dly = int'($urandom_range(1, 5));
         run_instr(op, 1'($urandom_range(0, 1)), dly);
      end

      @(negedge clk);
      chk("retires", 32'(retire_cnt), 32'(exp_retire));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
